// File: rtl/rns_to_bin_mrc.sv
// rns_to_bin_mrc
// Sequential reverse converter for a 3-channel residue number system.
// Rebuilds the binary integer X from three residues and their runtime moduli
// by mixed-radix conversion. Each mixed-radix digit is found by trying the
// candidates 0, 1, 2, ... one per clock, so no modular-inverse tables are needed.
// X = r1 + m1*a2 + m1*m2*a3
// Input and output each use a valid/ready handshake. Only one conversion is in
// flight at a time.

module rns_to_bin_mrc #(
    parameter int RW = 3,   // residue / modulus width per channel
    parameter int BW = 9    // binary result width (holds 7*7*7 - 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] res1,
    input  logic [RW-1:0] res2,
    input  logic [RW-1:0] res3,
    input  logic [RW-1:0] moduli1,
    input  logic [RW-1:0] moduli2,
    input  logic [RW-1:0] moduli3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] bin,
    output logic [BW-1:0] range_m,
    output logic          err
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE = 3'd0,   // waiting for a residue set
        CHK  = 3'd1,   // validate moduli and residues
        D2   = 3'd2,   // search for the second mixed-radix digit a2
        D3   = 3'd3,   // search for the third mixed-radix digit a3
        DONE = 3'd4    // hold the result until the consumer takes it
    } state_t;

    localparam logic [RW-1:0] ONE = RW'(1);
    localparam logic [RW-1:0] TWO = RW'(2);

    // Zero-extend a channel value to the arithmetic width.
    function automatic logic [BW-1:0] ext(input logic [RW-1:0] v);
        return BW'(v);
    endfunction

    // Remainder by a runtime modulus. A zero modulus only appears before a
    // valid set is captured; return 0 so nothing undefined reaches the compare.
    function automatic logic [BW-1:0] mod_bw(input logic [BW-1:0] a,
                                             input logic [BW-1:0] m);
        return (m == '0) ? '0 : (a % m);
    endfunction

    // ------------------------------------------------------------------
    // State and captured operands
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nx;

    logic [RW-1:0] r1_q, r2_q, r3_q;   // captured residues
    logic [RW-1:0] m1_q, m2_q, m3_q;   // captured moduli
    logic [RW-1:0] t_q;                // current search candidate
    logic [RW-1:0] a2_q;               // second mixed-radix digit
    logic [BW-1:0] bin_q;
    logic [BW-1:0] range_q;
    logic          err_q;

    // Control strobes from the FSM to the datapath
    logic          load;          // capture the input set
    logic          clr_t;         // restart the candidate counter
    logic          inc_t;         // advance to the next candidate
    logic          set_a2;        // current candidate is the digit a2
    logic          fin_ok;        // a3 found, publish X
    logic          fin_chk_err;   // moduli/residues rejected up front
    logic          fin_srch_err;  // a digit search ran out of candidates

    // ------------------------------------------------------------------
    // Search arithmetic (all BW bits wide, unsigned, never overflows)
    // ------------------------------------------------------------------
    logic [BW-1:0] r1_w, r2_w, r3_w;
    logic [BW-1:0] m1_w, m2_w, m3_w;
    logic [BW-1:0] t_w, a2_w;
    logic [BW-1:0] m12;        // m1*m2, weight of the third digit
    logic [BW-1:0] m123;       // dynamic range m1*m2*m3
    logic [BW-1:0] d2_val;     // r1 + m1*t
    logic [BW-1:0] base;       // r1 + m1*a2
    logic [BW-1:0] d3_val;     // base + m1*m2*t
    logic          d2_hit;
    logic          d3_hit;
    logic          t_last_d2;
    logic          t_last_d3;
    logic          chk_bad;

    // Candidate values and match tests for the current search step
    always_comb begin
        r1_w   = ext(r1_q);
        r2_w   = ext(r2_q);
        r3_w   = ext(r3_q);
        m1_w   = ext(m1_q);
        m2_w   = ext(m2_q);
        m3_w   = ext(m3_q);
        t_w    = ext(t_q);
        a2_w   = ext(a2_q);

        m12    = m1_w * m2_w;
        m123   = m12 * m3_w;

        d2_val = r1_w + m1_w * t_w;
        base   = r1_w + m1_w * a2_w;
        d3_val = base + m12 * t_w;

        d2_hit = (mod_bw(d2_val, m2_w) == r2_w);
        d3_hit = (mod_bw(d3_val, m3_w) == r3_w);

        t_last_d2 = (t_q == (m2_q - ONE));
        t_last_d3 = (t_q == (m3_q - ONE));

        chk_bad = (m1_q < TWO) || (m2_q < TWO) || (m3_q < TWO) ||
                  (r1_q >= m1_q) || (r2_q >= m2_q) || (r3_q >= m3_q);
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // Advance the conversion state; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, handshake outputs and datapath strobes
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_nx     = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        load         = 1'b0;
        clr_t        = 1'b0;
        inc_t        = 1'b0;
        set_a2       = 1'b0;
        fin_ok       = 1'b0;
        fin_chk_err  = 1'b0;
        fin_srch_err = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = CHK;
                end
            end

            CHK: begin
                if (chk_bad) begin
                    fin_chk_err = 1'b1;
                    state_nx    = DONE;
                end else begin
                    clr_t    = 1'b1;
                    state_nx = D2;
                end
            end

            D2: begin
                if (d2_hit) begin
                    set_a2   = 1'b1;
                    clr_t    = 1'b1;
                    state_nx = D3;
                end else if (t_last_d2) begin
                    fin_srch_err = 1'b1;
                    state_nx     = DONE;
                end else begin
                    inc_t = 1'b1;
                end
            end

            D3: begin
                if (d3_hit) begin
                    fin_ok   = 1'b1;
                    state_nx = DONE;
                end else if (t_last_d3) begin
                    fin_srch_err = 1'b1;
                    state_nx     = DONE;
                end else begin
                    inc_t = 1'b1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Capture operands, step the candidate counter and publish the result
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, so an aborted
        // search leaves no stale digit or result behind.
        if (rst) begin
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            m3_q    <= '0;
            t_q     <= '0;
            a2_q    <= '0;
            bin_q   <= '0;
            range_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (load) begin
                r1_q <= res1;
                r2_q <= res2;
                r3_q <= res3;
                m1_q <= moduli1;
                m2_q <= moduli2;
                m3_q <= moduli3;
            end

            if (clr_t) begin
                t_q <= '0;
            end else if (inc_t) begin
                t_q <= t_q + ONE;
            end

            if (set_a2) begin
                a2_q <= t_q;
            end

            if (fin_chk_err) begin
                bin_q   <= '0;
                err_q   <= 1'b1;
                range_q <= '0;
            end else if (fin_srch_err) begin
                bin_q   <= '0;
                err_q   <= 1'b1;
                range_q <= m123;
            end else if (fin_ok) begin
                bin_q   <= d3_val;
                err_q   <= 1'b0;
                range_q <= m123;
            end
        end
    end

    assign bin     = bin_q;
    assign range_m = range_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rns_to_bin_mrc.sv
// tb_rns_to_bin_mrc
// Directed bench for the MRC reverse converter. A behavioural model predicts
// bin, err, range_m and latency from the residues/moduli seen at acceptance;
// one compare process checks the DUT against it on every falling edge.

module tb_rns_to_bin_mrc;

    localparam int RW = 3;
    localparam int BW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] res1 = '0, res2 = '0, res3 = '0;
    logic [RW-1:0] moduli1 = '0, moduli2 = '0, moduli3 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] bin;
    logic [BW-1:0] range_m;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    rns_to_bin_mrc #(.RW(RW), .BW(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res1      (res1),
        .res2      (res2),
        .res3      (res3),
        .moduli1   (moduli1),
        .moduli2   (moduli2),
        .moduli3   (moduli3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin       (bin),
        .range_m   (range_m),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int bin;
        int err;
        int rng;
        int lat;
        int acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Mixed-radix conversion by plain search over the digit ranges.
    function automatic exp_t model(input int m1, input int m2, input int m3,
                                   input int r1, input int r2, input int r3);
        exp_t e;
        int   a2;
        int   a3;
        e.acc = 0;
        if (m1 < 2 || m2 < 2 || m3 < 2 || r1 >= m1 || r2 >= m2 || r3 >= m3) begin
            e.bin = 0; e.err = 1; e.rng = 0; e.lat = 1;
            return e;
        end
        e.rng = m1 * m2 * m3;
        a2 = -1;
        for (int t = 0; t < m2; t++) begin
            if ((r1 + m1 * t) % m2 == r2) begin a2 = t; break; end
        end
        if (a2 < 0) begin
            e.bin = 0; e.err = 1; e.lat = 1 + m2;
            return e;
        end
        a3 = -1;
        for (int t = 0; t < m3; t++) begin
            if ((r1 + m1 * a2 + m1 * m2 * t) % m3 == r3) begin a3 = t; break; end
        end
        if (a3 < 0) begin
            e.bin = 0; e.err = 1; e.lat = 1 + (a2 + 1) + m3;
        end else begin
            e.bin = r1 + m1 * a2 + m1 * m2 * a3;
            e.err = 0;
            e.lat = 1 + (a2 + 1) + (a3 + 1);
        end
        return e;
    endfunction

    // Compare process: every falling edge outside reset
    logic prev_ov = 1'b0;
    always @(negedge clk) begin : cmp
        exp_t e;
        if (rst) begin
            exp_q.delete();
            prev_ov = 1'b0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() == 0});
            if (exp_q.size() == 0) begin
                check("out_valid_idle", {31'd0, out_valid}, 32'd0);
            end else if (out_valid) begin
                e = exp_q[0];
                check("bin", 32'(bin), e.bin);
                check("err", {31'd0, err}, e.err);
                check("range_m", 32'(range_m), e.rng);
                if (!prev_ov) check("latency", cyc - e.acc, e.lat);
                if (out_ready) void'(exp_q.pop_front());
            end
            prev_ov = out_valid;
            if (in_valid && in_ready) begin
                e = model(int'(moduli1), int'(moduli2), int'(moduli3),
                          int'(res1), int'(res2), int'(res3));
                e.acc = cyc + 1;
                exp_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int m1, input int m2, input int m3,
                         input int r1, input int r2, input int r3);
        int n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        check("in_ready_within_bound", {31'd0, in_ready}, 32'd1);
        moduli1 = RW'(m1); moduli2 = RW'(m2); moduli3 = RW'(m3);
        res1 = RW'(r1); res2 = RW'(r2); res3 = RW'(r3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_conv(input int stall);
        int n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        check("out_valid_within_bound", {31'd0, out_valid}, 32'd1);
        // Stalled DONE: wiggle inputs and in_valid; nothing may change.
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            res1 = RW'($urandom); res2 = RW'($urandom); res3 = RW'($urandom);
            moduli1 = RW'($urandom); moduli2 = RW'($urandom); moduli3 = RW'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    // m1, m2, m3, r1, r2, r3, stall cycles
    localparam int NV = 15;
    int vec [NV][7] = '{
        '{3, 5, 7, 1, 2, 3, 0},   // X = 52
        '{3, 5, 7, 0, 0, 0, 0},   // X = 0, minimum latency
        '{3, 5, 7, 2, 4, 6, 2},   // X = 104
        '{2, 4, 7, 0, 1, 0, 0},   // D2 exhausts
        '{3, 5, 7, 5, 0, 0, 0},   // residue >= modulus
        '{3, 1, 7, 0, 0, 0, 0},   // modulus below 2
        '{0, 5, 7, 0, 0, 0, 0},   // zero modulus
        '{3, 5, 7, 0, 1, 7, 0},   // r3 == m3
        '{5, 6, 7, 4, 3, 2, 1},
        '{7, 5, 6, 6, 4, 5, 0},
        '{2, 3, 5, 1, 2, 4, 0},
        '{7, 7, 7, 3, 3, 3, 0},   // non-coprime, consistent
        '{2, 7, 7, 0, 5, 1, 0},   // a2 = 6 then D3 exhausts, 15 cycles
        '{7, 6, 5, 6, 5, 4, 0},
        '{3, 5, 7, 1, 2, 3, 10}   // long stall with toggling inputs
    };

    initial begin : main
        exp_t p;

        // Pin the model against hand-worked values
        p = model(3, 5, 7, 1, 2, 3);
        check("model_case1_bin", p.bin, 52);
        check("model_case1_lat", p.lat, 8);
        check("model_case1_rng", p.rng, 105);
        p = model(3, 5, 7, 2, 4, 6);
        check("model_104_bin", p.bin, 104);
        check("model_104_lat", p.lat, 13);
        p = model(2, 4, 7, 0, 1, 0);
        check("model_exhaust_err", p.err, 1);
        check("model_exhaust_lat", p.lat, 5);
        check("model_exhaust_rng", p.rng, 56);
        p = model(3, 5, 7, 0, 0, 0);
        check("model_zero_lat", p.lat, 3);
        p = model(2, 7, 7, 0, 5, 1);
        check("model_max_lat", p.lat, 15);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bin", 32'(bin), 32'd0);
        check("rst_range_m", 32'(range_m), 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            start(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], vec[i][5]);
            finish_conv(vec[i][6]);
        end

        // No spurious second result after the stalled transfer
        repeat (4) tick();
        check("no_second_result", {31'd0, out_valid}, 32'd0);

        // Reset during the D2 search of case 1
        start(3, 5, 7, 1, 2, 3);   // now in CHK
        tick();                    // D2, t = 0
        tick();                    // D2, t = 1
        rst = 1'b1;
        tick();
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_bin", 32'(bin), 32'd0);
        check("midrst_range_m", 32'(range_m), 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        check("midrst_no_result", {31'd0, out_valid}, 32'd0);

        // Fresh conversion after the abort
        start(3, 5, 7, 1, 2, 3);
        finish_conv(0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
